// File: rtl/snow_vi_aes_inv_round_pkg.sv
// Shared AES round helpers: GF(2^8) multiplies, (inverse) MixColumns and ShiftRows,
// and the inverse S-box byte table, so encipher and inverse rounds agree on byte order.
package snow_vi_aes_inv_round_pkg;

  // Entry 0 sits in the top byte; row k of the table covers inputs 16k..16k+15.
  localparam logic [2047:0] INV_SBOX_TBL = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] inv_sbox_byte(input logic [7:0] x);
    return INV_SBOX_TBL[8*(255-int'(x)) +: 8];
  endfunction

  function automatic logic [7:0] gm2(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm3(input logic [7:0] b);
    return gm2(b) ^ b;
  endfunction

  function automatic logic [7:0] gm09(input logic [7:0] b);
    return gm2(gm2(gm2(b))) ^ b;
  endfunction

  function automatic logic [7:0] gm0b(input logic [7:0] b);
    return gm2(gm2(gm2(b))) ^ gm2(b) ^ b;
  endfunction

  function automatic logic [7:0] gm0d(input logic [7:0] b);
    return gm2(gm2(gm2(b))) ^ gm2(gm2(b)) ^ b;
  endfunction

  function automatic logic [7:0] gm0e(input logic [7:0] b);
    return gm2(gm2(gm2(b))) ^ gm2(gm2(b)) ^ gm2(b);
  endfunction

  function automatic logic [31:0] mixw(input logic [31:0] w);
    logic [7:0] b0, b1, b2, b3;
    {b0, b1, b2, b3} = w;
    return {gm2(b0) ^ gm3(b1) ^ b2 ^ b3, b0 ^ gm2(b1) ^ gm3(b2) ^ b3,
            b0 ^ b1 ^ gm2(b2) ^ gm3(b3), gm3(b0) ^ b1 ^ b2 ^ gm2(b3)};
  endfunction

  function automatic logic [31:0] inv_mixw(input logic [31:0] w);
    logic [7:0] b0, b1, b2, b3;
    {b0, b1, b2, b3} = w;
    return {gm0e(b0) ^ gm0b(b1) ^ gm0d(b2) ^ gm09(b3),
            gm09(b0) ^ gm0e(b1) ^ gm0b(b2) ^ gm0d(b3),
            gm0d(b0) ^ gm09(b1) ^ gm0e(b2) ^ gm0b(b3),
            gm0b(b0) ^ gm0d(b1) ^ gm09(b2) ^ gm0e(b3)};
  endfunction

  function automatic logic [127:0] inv_mix_block(input logic [127:0] s);
    return {inv_mixw(s[127:96]), inv_mixw(s[95:64]), inv_mixw(s[63:32]), inv_mixw(s[31:0])};
  endfunction

  function automatic logic [127:0] shiftrows(input logic [127:0] s);
    logic [31:0] w [4];
    logic [31:0] ws [4];
    for (int i = 0; i < 4; i++) w[i] = s[32*(3-i) +: 32];
    for (int i = 0; i < 4; i++)
      ws[i] = {w[i][31:24], w[(i+1)%4][23:16], w[(i+2)%4][15:8], w[(i+3)%4][7:0]};
    return {ws[0], ws[1], ws[2], ws[3]};
  endfunction

  function automatic logic [127:0] inv_shiftrows(input logic [127:0] s);
    logic [31:0] w [4];
    logic [31:0] ws [4];
    for (int i = 0; i < 4; i++) w[i] = s[32*(3-i) +: 32];
    for (int i = 0; i < 4; i++)
      ws[i] = {w[i][31:24], w[(i+3)%4][23:16], w[(i+2)%4][15:8], w[(i+1)%4][7:0]};
    return {ws[0], ws[1], ws[2], ws[3]};
  endfunction

endpackage

// File: rtl/snow_vi_aes_inv_round_if.sv
// Start/ready request bus and registered result outputs of the inverse round.
interface snow_vi_aes_inv_round_if;
  logic         start;
  logic [127:0] block;
  logic         ready;
  logic         valid;
  logic [127:0] new_block;

  modport master (output start, output block, input ready, input valid, input new_block);
  modport slave  (input start, input block, output ready, output valid, output new_block);
endinterface

// File: rtl/snow_vi_aes_inv_sbox.sv
// Combinational inverse S-box word: four independent byte lookups.
module snow_vi_aes_inv_sbox
  import snow_vi_aes_inv_round_pkg::*;
(
  input  logic [31:0] word_in,
  output logic [31:0] word_out
);

  for (genvar i = 0; i < 4; i++) begin : g_byte
    assign word_out[8*i +: 8] = inv_sbox_byte(word_in[8*i +: 8]);
  end

endmodule

// File: rtl/snow_vi_aes_inv_round.sv
// Iterative keyless AES inverse round: one MIX cycle, then four SUB cycles sharing
// a single inverse S-box word.
module snow_vi_aes_inv_round
  import snow_vi_aes_inv_round_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset_n,
  snow_vi_aes_inv_round_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, MIX, SUB} state_e;

  state_e       state_q, state_d;
  logic [1:0]   word_ctr_q, word_ctr_d;
  logic [127:0] block_reg_q, block_reg_d;
  logic [127:0] new_block_q, new_block_d;
  logic         valid_q, valid_d;
  logic [31:0]  sbox_in, sbox_out;
  logic [127:0] block_sub;

  snow_vi_aes_inv_sbox u_inv_sbox (
    .word_in  (sbox_in),
    .word_out (sbox_out)
  );

  // Word 0 is the most significant column, so the counter walks the block top-down.
  always_comb begin
    sbox_in   = block_reg_q[32*(3-int'(word_ctr_q)) +: 32];
    block_sub = block_reg_q;
    block_sub[32*(3-int'(word_ctr_q)) +: 32] = sbox_out;
  end

  always_comb begin
    state_d     = state_q;
    word_ctr_d  = word_ctr_q;
    block_reg_d = block_reg_q;
    new_block_d = new_block_q;
    valid_d     = valid_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          block_reg_d = bus.block;
          valid_d     = 1'b0;
          state_d     = MIX;
        end
      end
      MIX: begin
        block_reg_d = inv_shiftrows(inv_mix_block(block_reg_q));
        word_ctr_d  = 2'd0;
        state_d     = SUB;
      end
      SUB: begin
        block_reg_d = block_sub;
        word_ctr_d  = word_ctr_q + 2'd1;
        // The result register takes the block including this cycle's last word.
        if (word_ctr_q == 2'd3) begin
          new_block_d = block_sub;
          valid_d     = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      word_ctr_q  <= 2'd0;
      block_reg_q <= '0;
      new_block_q <= '0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      word_ctr_q  <= word_ctr_d;
      block_reg_q <= block_reg_d;
      new_block_q <= new_block_d;
      valid_q     <= valid_d;
    end
  end

  assign bus.ready     = (state_q == IDLE);
  assign bus.valid     = valid_q;
  assign bus.new_block = new_block_q;

endmodule

// File: tb/tb_snow_vi_aes_inv_round.sv
// Directed and randomized checks of the iterative AES inverse round against an
// independent forward-round model built from GF(2^8) arithmetic.
module tb_snow_vi_aes_inv_round;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_cmp = 0;
  int   n_fail = 0;
  logic [7:0] sbox [256];

  localparam logic [127:0] ZERO_BLK = '0;
  localparam logic [127:0] ALL52    = {16{8'h52}};
  localparam logic [127:0] ALL63    = {16{8'h63}};
  localparam logic [127:0] ALLFF    = {16{8'hff}};
  localparam logic [127:0] FIPS_IN  = 128'h046681e5e0cb199a48f8d37a2806264c;
  localparam logic [127:0] FIPS_OUT = 128'h193de3bea0f4e22b9ac68d2ae9f84808;

  snow_vi_aes_inv_round_if bus ();

  snow_vi_aes_inv_round dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    logic [7:0] b;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      b = inv;
      sbox[x] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    end
  endtask

  // Forward keyless round: MixColumns(ShiftRows(SubBytes(s))).
  function automatic logic [127:0] fwd_round(input logic [127:0] s);
    logic [7:0] a [16];
    logic [7:0] t [16];
    logic [127:0] r;
    for (int i = 0; i < 16; i++) a[i] = sbox[s[127-8*i -: 8]];
    for (int c = 0; c < 4; c++)
      for (int rw = 0; rw < 4; rw++) t[4*c+rw] = a[4*((c+rw)%4)+rw];
    for (int c = 0; c < 4; c++) begin
      r[127-32*c -: 8]  = gmul(8'h02, t[4*c]) ^ gmul(8'h03, t[4*c+1]) ^ t[4*c+2] ^ t[4*c+3];
      r[119-32*c -: 8]  = t[4*c] ^ gmul(8'h02, t[4*c+1]) ^ gmul(8'h03, t[4*c+2]) ^ t[4*c+3];
      r[111-32*c -: 8]  = t[4*c] ^ t[4*c+1] ^ gmul(8'h02, t[4*c+2]) ^ gmul(8'h03, t[4*c+3]);
      r[103-32*c -: 8]  = gmul(8'h03, t[4*c]) ^ t[4*c+1] ^ t[4*c+2] ^ gmul(8'h02, t[4*c+3]);
    end
    return r;
  endfunction

  // Launches one request and waits (bounded) for valid; counts cycles and ready-low samples.
  task automatic run_op(input logic [127:0] blk, output int lat, output int rdy_low, output bit timeout);
    @(negedge clk);
    bus.start = 1'b1;
    bus.block = blk;
    lat = 0;
    rdy_low = 0;
    timeout = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 0) bus.start = 1'b0;
      lat++;
      if (!bus.ready) rdy_low++;
      if (bus.valid) begin
        timeout = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if (bus.ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", bus.ready); end
    n_cmp++;
    if (bus.valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", bus.valid); end
    n_cmp++;
    if (bus.new_block !== ZERO_BLK) begin n_fail++; $display("FAIL reset_new_block: got %h want 0", bus.new_block); end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_vector(input string name, input logic [127:0] blk, input logic [127:0] exp);
    int lat, rdy_low;
    bit to;
    run_op(blk, lat, rdy_low, to);
    n_cmp++;
    if (to) begin n_fail++; $display("FAIL %s_timeout: valid never rose within 20 cycles", name); end
    n_cmp++;
    if (bus.new_block !== exp) begin n_fail++; $display("FAIL %s_result: got %h want %h", name, bus.new_block, exp); end
    n_cmp++;
    if (lat != 6) begin n_fail++; $display("FAIL %s_latency: got %0d want 6", name, lat); end
    n_cmp++;
    if (rdy_low != 5 || bus.ready !== 1'b1) begin
      n_fail++; $display("FAIL %s_ready: low samples %0d ready %b want 5 and 1", name, rdy_low, bus.ready);
    end
  endtask

  task automatic test_busy_start();
    bit ok;
    int cnt;
    @(negedge clk);
    bus.start = 1'b1;
    bus.block = ZERO_BLK;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.block = ALLFF;
    @(negedge clk);
    bus.start = 1'b0;
    bus.block = ZERO_BLK;
    cnt = 0;
    while (!bus.valid && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    n_cmp++;
    if (cnt != 3) begin n_fail++; $display("FAIL busy_latency: got %0d extra cycles want 3", cnt); end
    n_cmp++;
    if (bus.new_block !== ALL52) begin n_fail++; $display("FAIL busy_result: got %h want %h", bus.new_block, ALL52); end
    ok = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.ready !== 1'b1 || bus.valid !== 1'b1 || bus.new_block !== ALL52) ok = 1'b0;
    end
    n_cmp++;
    if (!ok) begin n_fail++; $display("FAIL busy_no_second_op: got ready %b valid %b data %h want 1 1 %h", bus.ready, bus.valid, bus.new_block, ALL52); end
  endtask

  task automatic test_back_to_back();
    int cnt;
    @(negedge clk);
    bus.start = 1'b1;
    bus.block = ALL63;
    @(negedge clk);
    bus.block = FIPS_IN;
    cnt = 1;
    while (!bus.valid && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    n_cmp++;
    if (bus.new_block !== ZERO_BLK || cnt != 6) begin
      n_fail++; $display("FAIL b2b_first: got %h after %0d want 0 after 6", bus.new_block, cnt);
    end
    @(negedge clk);
    bus.start = 1'b0;
    n_cmp++;
    if (bus.valid !== 1'b0 || bus.ready !== 1'b0) begin
      n_fail++; $display("FAIL b2b_accept: got valid %b ready %b want 0 0", bus.valid, bus.ready);
    end
    cnt = 0;
    while (!bus.valid && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    n_cmp++;
    if (bus.new_block !== FIPS_OUT || cnt != 5) begin
      n_fail++; $display("FAIL b2b_second: got %h after %0d want %h after 5", bus.new_block, cnt, FIPS_OUT);
    end
  endtask

  task automatic test_abort();
    @(negedge clk);
    bus.start = 1'b1;
    bus.block = ALL63;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if (bus.ready !== 1'b1 || bus.valid !== 1'b0 || bus.new_block !== ZERO_BLK) begin
      n_fail++; $display("FAIL abort_outputs: got ready %b valid %b data %h want 1 0 0", bus.ready, bus.valid, bus.new_block);
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    test_vector("after_abort", ZERO_BLK, ALL52);
  endtask

  task automatic test_random();
    logic [127:0] blk;
    int lat, rdy_low;
    bit to;
    for (int n = 0; n < 2000; n++) begin
      blk = {$urandom, $urandom, $urandom, $urandom};
      run_op(blk, lat, rdy_low, to);
      n_cmp++;
      if (to || fwd_round(bus.new_block) !== blk) begin
        n_fail++; $display("FAIL random_%0d: in %h out %h reenc %h", n, blk, bus.new_block, fwd_round(bus.new_block));
      end
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.block = '0;
    build_sbox();
    test_reset();
    test_vector("zero", ZERO_BLK, ALL52);
    test_vector("const63", ALL63, ZERO_BLK);
    test_vector("fips", FIPS_IN, FIPS_OUT);
    test_busy_start();
    test_back_to_back();
    test_abort();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
